// File: rtl/ramreader.sv
// Drains committed 64-bit words from a ring RAM and hands them to a consumer
// as four signed 16-bit samples (oldest lane first) over a valid/ready handshake.
module ramreader #(
  parameter int RD_LATENCY = 2,
  parameter int DEPTH      = 2048
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wbit,
  input  logic [63:0] i_rd_data,
  output logic [13:0] o_rd_address,
  output logic        o_rd_en,
  output logic [15:0] o_sample,
  output logic        o_sample_valid,
  input  logic        i_sample_ready,
  output logic [11:0] o_fill,
  output logic        o_overrun
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_REQ  = 2'd1,
    WAIT_DATA = 2'd2,
    SHIFT_OUT = 2'd3
  } state_t;

  localparam logic [11:0] FILL_MAX  = 12'(DEPTH);
  localparam logic [13:0] LAST_ADDR = 14'(DEPTH - 1);
  localparam logic [2:0]  LAST_WAIT = 3'(RD_LATENCY - 1);

  state_t      state_reg;
  logic        wbit_reg;
  logic        commit;
  logic        rd_req;
  logic [63:0] hold_reg;
  logic [1:0]  lane_reg;
  logic [2:0]  wait_cnt_reg;
  logic [15:0] lane_word [4];

  // Lane 0 is the oldest sample, held in the top 16 bits of the word.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_word[gi] = hold_reg[63-16*gi -: 16];
    end
  endgenerate

  assign commit = wbit_reg & ~i_wbit;
  assign rd_req = (state_reg == READ_REQ);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wbit_reg <= 1'b0;
    end else begin
      wbit_reg <= i_wbit;
    end
  end

  // A commit landing in the request cycle cancels the decrement.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_fill    <= 12'd0;
      o_overrun <= 1'b0;
    end else if (commit && !rd_req) begin
      if (o_fill == FILL_MAX) begin
        o_overrun <= 1'b1;
      end else begin
        o_fill <= o_fill + 12'd1;
      end
    end else if (rd_req && !commit && o_fill != 12'd0) begin
      o_fill <= o_fill - 12'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg      <= IDLE;
      o_rd_address   <= 14'd0;
      o_rd_en        <= 1'b0;
      o_sample       <= 16'd0;
      o_sample_valid <= 1'b0;
      hold_reg       <= 64'd0;
      lane_reg       <= 2'd0;
      wait_cnt_reg   <= 3'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          o_sample_valid <= 1'b0;
          if (o_fill != 12'd0) begin
            o_rd_en   <= 1'b1;
            state_reg <= READ_REQ;
          end
        end
        READ_REQ: begin
          o_rd_en      <= 1'b0;
          wait_cnt_reg <= 3'd0;
          state_reg    <= WAIT_DATA;
        end
        WAIT_DATA: begin
          if (wait_cnt_reg == LAST_WAIT) begin
            hold_reg       <= i_rd_data;
            o_sample       <= i_rd_data[63:48];
            o_sample_valid <= 1'b1;
            lane_reg       <= 2'd0;
            wait_cnt_reg   <= 3'd0;
            state_reg      <= SHIFT_OUT;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 3'd1;
          end
        end
        SHIFT_OUT: begin
          if (o_sample_valid && i_sample_ready) begin
            if (lane_reg == 2'd3) begin
              o_sample_valid <= 1'b0;
              o_rd_address   <= (o_rd_address == LAST_ADDR) ? 14'd0 : o_rd_address + 14'd1;
              lane_reg       <= 2'd0;
              state_reg      <= IDLE;
            end else begin
              lane_reg <= lane_reg + 2'd1;
              o_sample <= lane_word[lane_reg + 2'd1];
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ramreader.sv
// Scoreboard bench for ramreader: a RAM model with fixed read latency, commits
// push expected addresses/samples, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_ramreader;
  localparam int RD_LATENCY = 2;
  localparam int DEPTH      = 2048;
  localparam int AW         = $clog2(DEPTH);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wbit = 1'b0;
  logic [63:0] rd_data;
  logic [13:0] o_rd_address;
  logic        o_rd_en;
  logic [15:0] o_sample;
  logic        o_sample_valid;
  logic        ready = 1'b0;
  logic [11:0] o_fill;
  logic        o_overrun;

  always #5 clk = ~clk;

  ramreader #(.RD_LATENCY(RD_LATENCY), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_wbit(wbit), .i_rd_data(rd_data),
    .o_rd_address(o_rd_address), .o_rd_en(o_rd_en), .o_sample(o_sample),
    .o_sample_valid(o_sample_valid), .i_sample_ready(ready),
    .o_fill(o_fill), .o_overrun(o_overrun)
  );

  // RAM model: data is valid for exactly one cycle, RD_LATENCY cycles after the request
  logic [63:0] mem [DEPTH];
  logic [63:0] rd_pipe [RD_LATENCY];
  always @(posedge clk) begin
    for (int k = RD_LATENCY - 1; k > 0; k--) rd_pipe[k] <= rd_pipe[k-1];
    rd_pipe[0] <= o_rd_en ? mem[o_rd_address[AW-1:0]] : 64'h5A5A_A5A5_5A5A_A5A5;
  end
  assign rd_data = rd_pipe[RD_LATENCY-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] exp_samp_q [$];
  logic [13:0] exp_addr_q [$];
  int          acc_cycle_q [$];
  logic [AW-1:0] wr_ptr = '0;
  int pass_cnt = 0;
  int check_cnt = 0;
  int rd_count = 0;

  // Monitor: compares every read request and every accepted sample
  initial begin
    logic        prev_hold;
    logic [15:0] prev_sample;
    logic        await_first;
    int          rd_cycle;
    logic [13:0] ea;
    logic [15:0] es;
    prev_hold = 1'b0; prev_sample = '0; await_first = 1'b0; rd_cycle = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_hold = 1'b0;
        await_first = 1'b0;
      end else begin
        if (o_rd_en) begin
          check_cnt++;
          if (exp_addr_q.size() == 0) $display("FAIL rd_addr: unexpected read at %0d, required none", o_rd_address);
          else begin
            ea = exp_addr_q.pop_front();
            if (o_rd_address !== ea) $display("FAIL rd_addr: got %0d required %0d", o_rd_address, ea);
            else pass_cnt++;
          end
          check_cnt++;
          if (o_fill == 12'd0) $display("FAIL rd_en_fill: got fill %0d required nonzero", o_fill);
          else pass_cnt++;
          $display("read %0d addr %0d fill %0d", rd_count, o_rd_address, o_fill);
          rd_count++;
          await_first = 1'b1;
          rd_cycle = cyc;
        end
        if (prev_hold) begin
          check_cnt++;
          if (o_sample_valid !== 1'b1 || o_sample !== prev_sample)
            $display("FAIL hold: got valid %0b sample %h required valid 1 sample %h", o_sample_valid, o_sample, prev_sample);
          else pass_cnt++;
        end
        if (o_sample_valid && await_first) begin
          check_cnt++;
          if (cyc - rd_cycle !== RD_LATENCY + 1)
            $display("FAIL latency: got %0d cycles required %0d", cyc - rd_cycle, RD_LATENCY + 1);
          else pass_cnt++;
          await_first = 1'b0;
        end
        if (o_sample_valid && ready) begin
          check_cnt++;
          if (exp_samp_q.size() == 0) $display("FAIL sample: got %h required none", o_sample);
          else begin
            es = exp_samp_q.pop_front();
            if (o_sample !== es) $display("FAIL sample: got %h required %h", o_sample, es);
            else pass_cnt++;
          end
          acc_cycle_q.push_back(cyc);
        end
        prev_hold = o_sample_valid && !ready;
        prev_sample = o_sample;
      end
    end
  end

  task automatic push_word(input logic [63:0] data);
    mem[wr_ptr] = data;
    exp_addr_q.push_back(14'(wr_ptr));
    exp_samp_q.push_back(data[63:48]);
    exp_samp_q.push_back(data[47:32]);
    exp_samp_q.push_back(data[31:16]);
    exp_samp_q.push_back(data[15:0]);
    wr_ptr = wr_ptr + 1'b1;
  endtask

  // Called at posedge+1; returns at posedge+1 with the commit reflected in o_fill
  task automatic commit_word(input logic [63:0] data, input bit store);
    if (store) push_word(data);
    wbit = 1'b1;
    @(posedge clk); #1;
    wbit = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    wbit = 1'b0;
    exp_samp_q.delete(); exp_addr_q.delete(); acc_cycle_q.delete();
    wr_ptr = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((exp_samp_q.size() != 0 || o_fill != 12'd0 || o_sample_valid) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check_cnt++;
    if (exp_samp_q.size() != 0 || o_fill != 12'd0 || o_sample_valid)
      $display("FAIL %s_drain: got %0d samples pending fill %0d required 0 after %0d cycles", name, exp_samp_q.size(), o_fill, budget);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1;
    check_cnt++;
    if ({o_rd_address, o_rd_en, o_sample, o_sample_valid, o_fill, o_overrun} !== 45'd0)
      $display("FAIL reset_outputs: got addr %0d en %0b sample %h valid %0b fill %0d ovr %0b required all 0",
               o_rd_address, o_rd_en, o_sample, o_sample_valid, o_fill, o_overrun);
    else pass_cnt++;
    ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    check_cnt++;
    if (o_fill !== 12'd0 || rd_count != 0)
      $display("FAIL reset_no_commit: got fill %0d reads %0d required 0 0", o_fill, rd_count);
    else pass_cnt++;
  endtask

  task automatic test_single();
    acc_cycle_q.delete();
    commit_word(64'h8000_8001_8002_8003, 1'b1);
    check_cnt++;
    if (o_fill !== 12'd1) $display("FAIL single_fill1: got %0d required 1", o_fill);
    else pass_cnt++;
    wait_idle("single", 50);
    check_cnt++;
    if (acc_cycle_q.size() != 4 || acc_cycle_q[3] - acc_cycle_q[0] != 3)
      $display("FAIL single_consecutive: got %0d samples span %0d required 4 span 3",
               acc_cycle_q.size(), acc_cycle_q.size() == 4 ? acc_cycle_q[3] - acc_cycle_q[0] : -1);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    int n = 0;
    acc_cycle_q.delete();
    ready = 1'b1;
    commit_word({$urandom, $urandom}, 1'b1);
    while (!o_sample_valid && n < 50) begin @(posedge clk); #1; n++; end
    check_cnt++;
    if (!o_sample_valid) $display("FAIL bp_valid: got valid 0 required 1");
    else pass_cnt++;
    for (int i = 0; i < 6; i++) begin
      ready = pat[i];
      @(posedge clk); #1;
    end
    ready = 1'b1;
    wait_idle("bp", 50);
    check_cnt++;
    if (acc_cycle_q.size() != 4) $display("FAIL bp_count: got %0d samples required 4", acc_cycle_q.size());
    else pass_cnt++;
  endtask

  task automatic test_coincident();
    commit_word({$urandom, $urandom}, 1'b1);
    check_cnt++;
    if (o_fill !== 12'd1) $display("FAIL coinc_fill_a: got %0d required 1", o_fill);
    else pass_cnt++;
    push_word({$urandom, $urandom});
    wbit = 1'b1;
    @(posedge clk); #1;
    check_cnt++;
    if (o_rd_en !== 1'b1 || o_fill !== 12'd1)
      $display("FAIL coinc_req: got en %0b fill %0d required 1 1", o_rd_en, o_fill);
    else pass_cnt++;
    wbit = 1'b0;
    @(posedge clk); #1;
    check_cnt++;
    if (o_fill !== 12'd1) $display("FAIL coinc_fill_b: got %0d required 1", o_fill);
    else pass_cnt++;
    wait_idle("coinc", 100);
  endtask

  task automatic test_back_to_back();
    int n = 0;
    for (int i = 0; i < 6; i++) commit_word({$urandom, $urandom}, 1'b1);
    while ((exp_samp_q.size() != 0 || o_fill != 12'd0 || o_sample_valid) && n < 400) begin
      ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    ready = 1'b1;
    wait_idle("b2b", 50);
  endtask

  task automatic test_wrap();
    int start_reads;
    do_reset();
    ready = 1'b1;
    start_reads = rd_count;
    for (int i = 0; i < DEPTH + 1; i++) commit_word({$urandom, $urandom}, 1'b1);
    wait_idle("wrap", 20000);
    check_cnt++;
    if (rd_count - start_reads != DEPTH + 1 || o_overrun !== 1'b0)
      $display("FAIL wrap: got %0d reads overrun %0b required %0d 0", rd_count - start_reads, o_overrun, DEPTH + 1);
    else pass_cnt++;
  endtask

  task automatic test_overrun();
    int n = 0;
    do_reset();
    ready = 1'b1;
    commit_word({$urandom, $urandom}, 1'b1);
    while (!o_rd_en && n < 20) begin @(posedge clk); #1; n++; end
    ready = 1'b0;
    check_cnt++;
    if (o_rd_en !== 1'b1) $display("FAIL ovr_first_read: got en %0b required 1", o_rd_en);
    else pass_cnt++;
    for (int i = 0; i < DEPTH; i++) commit_word({$urandom, $urandom}, 1'b1);
    check_cnt++;
    if (o_fill !== 12'(DEPTH) || o_overrun !== 1'b0)
      $display("FAIL ovr_full: got fill %0d overrun %0b required %0d 0", o_fill, o_overrun, DEPTH);
    else pass_cnt++;
    commit_word({$urandom, $urandom}, 1'b0);
    check_cnt++;
    if (o_fill !== 12'(DEPTH) || o_overrun !== 1'b1)
      $display("FAIL ovr_extra: got fill %0d overrun %0b required %0d 1", o_fill, o_overrun, DEPTH);
    else pass_cnt++;
    repeat (3) begin @(posedge clk); #1; end
    check_cnt++;
    if (o_overrun !== 1'b1) $display("FAIL ovr_sticky: got %0b required 1", o_overrun);
    else pass_cnt++;
    do_reset();
    ready = 1'b1;
    check_cnt++;
    if (o_overrun !== 1'b0 || o_fill !== 12'd0)
      $display("FAIL ovr_clear: got overrun %0b fill %0d required 0 0", o_overrun, o_fill);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    do_reset();
    ready = 1'b1;
    commit_word({$urandom, $urandom}, 1'b1);
    wait_idle("mid_a", 50);
    commit_word({$urandom, $urandom}, 1'b1);
    while (!o_rd_en && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    #1 rst_n = 1'b0;
    #1;
    check_cnt++;
    if ({o_rd_address, o_rd_en, o_sample, o_sample_valid, o_fill, o_overrun} !== 45'd0)
      $display("FAIL mid_reset: got addr %0d en %0b sample %h valid %0b fill %0d ovr %0b required all 0",
               o_rd_address, o_rd_en, o_sample, o_sample_valid, o_fill, o_overrun);
    else pass_cnt++;
    exp_samp_q.delete(); exp_addr_q.delete(); acc_cycle_q.delete();
    wr_ptr = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    commit_word({$urandom, $urandom}, 1'b1);
    wait_idle("mid_b", 50);
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_coincident();
    test_back_to_back();
    test_reset_mid();
    test_overrun();
    test_wrap();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
